// File: rtl/lcd_msg_writer.sv
// Display end of the controller message bus: looks up a 2x16 text per 4-bit code and
// writes it to an HD44780 (8-bit, write-only), after a one-time power-up/init sequence.
module lcd_msg_writer #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int PWRUP_US = 15_000,
  parameter int EN_CYC   = 25,
  parameter int CMD_US   = 50,
  parameter int CLR_US   = 2_000
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [3:0] mensaje,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       busy,
  output logic       done
);

  localparam logic [63:0] US_DIV   = 64'd1_000_000;
  localparam logic [26:0] PWRUP_LD = 27'(64'(PWRUP_US) * 64'(CLK_HZ) / US_DIV - 64'd1);
  localparam logic [26:0] CMD_LD   = 27'(64'(CMD_US) * 64'(CLK_HZ) / US_DIV - 64'd1);
  localparam logic [26:0] CLR_LD   = 27'(64'(CLR_US) * 64'(CLK_HZ) / US_DIV - 64'd1);
  localparam logic [26:0] EN_LD    = 27'(EN_CYC - 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_CLEAR, S_L1ADDR, S_L1, S_L2ADDR, S_L2
  } state_t;
  typedef enum logic [1:0] {P_SETUP, P_EN, P_WAIT} phase_t;

  state_t      state;
  phase_t      phase;
  logic [26:0] cnt;
  logic [2:0]  init_idx;
  logic [3:0]  col;
  logic [3:0]  cur_code;
  logic        pend;
  logic        rewriting;

  assign lcd_rw    = 1'b0;
  assign rewriting = (state != S_PWRUP) && (state != S_INIT) && (state != S_IDLE);

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_cmd = 8'h38;
      3'd3:             init_cmd = 8'h0C;
      3'd4:             init_cmd = 8'h06;
      default:          init_cmd = 8'h01;
    endcase
  endfunction

  // Both lines of one message, line 1 in the upper 128 bits, first char at the MSB.
  function automatic logic [255:0] msg_text(input logic [3:0] code);
    case (code)
      4'd0:  msg_text = {"Bienvenido a", {4{8'h20}}, "SCAAD", {11{8'h20}}};
      4'd1:  msg_text = {"Inserte moneda", {2{8'h20}}, "para iniciar", {4{8'h20}}};
      4'd3:  msg_text = {"Ducha activa", {4{8'h20}}, "Agua caliente", {3{8'h20}}};
      4'd4:  msg_text = {"Ducha activa", {4{8'h20}}, "Agua fria", {7{8'h20}}};
      4'd5:  msg_text = {"Tiempo agotado", {2{8'h20}}, "Gracias", {9{8'h20}}};
      4'd6:  msg_text = {"Pausa", {11{8'h20}}, "Presione boton", {2{8'h20}}};
      4'd7:  msg_text = {"Error sensor", {4{8'h20}}, "Llame soporte", {3{8'h20}}};
      4'd8:  msg_text = {"Fin de ducha", {4{8'h20}}, "Hasta pronto", {4{8'h20}}};
      4'd9:  msg_text = {"Saldo bajo", {6{8'h20}}, "Inserte moneda", {2{8'h20}}};
      4'd10: msg_text = {"Calentando agua", 8'h20, "Espere por favor"};
      4'd11: msg_text = {"Temperatura alta", "Ajuste mezcla", {3{8'h20}}};
      4'd12: msg_text = {"Puerta abierta", {2{8'h20}}, "Cierre la puerta"};
      4'd13: msg_text = {"Mantenimiento", {3{8'h20}}, "Fuera de servic."};
      4'd14: msg_text = {"Modo prueba", {5{8'h20}}, "SCAAD v1.0", {6{8'h20}}};
      default: msg_text = {32{8'h20}};
    endcase
  endfunction

  function automatic logic [7:0] rom_char(input logic [3:0] code, input logic line,
                                          input logic [3:0] c);
    logic [255:0] t;
    t = msg_text(code) << {line, c, 3'b000};
    return t[255:248];
  endfunction

  always_ff @(posedge Clk) begin
    if (reset) begin
      state    <= S_PWRUP;
      phase    <= P_SETUP;
      cnt      <= PWRUP_LD;
      init_idx <= 3'd0;
      col      <= 4'd0;
      cur_code <= 4'hF;
      pend     <= 1'b0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      // Any code change during a rewrite is remembered; the in-flight byte still finishes.
      if (rewriting && mensaje != cur_code) pend <= 1'b1;
      case (state)
        S_PWRUP: begin
          if (cnt != 27'd0) cnt <= cnt - 27'd1;
          else begin
            state    <= S_INIT;
            init_idx <= 3'd0;
            phase    <= P_SETUP;
            lcd_data <= init_cmd(3'd0);
            lcd_rs   <= 1'b0;
          end
        end
        S_IDLE: begin
          if (mensaje != cur_code) begin
            cur_code <= mensaje;
            busy     <= 1'b1;
            pend     <= 1'b0;
            state    <= S_CLEAR;
            phase    <= P_SETUP;
            lcd_data <= 8'h01;
            lcd_rs   <= 1'b0;
          end
        end
        default: begin
          case (phase)
            P_SETUP: begin
              lcd_en <= 1'b1;
              phase  <= P_EN;
              cnt    <= EN_LD;
            end
            P_EN: begin
              if (cnt != 27'd0) cnt <= cnt - 27'd1;
              else begin
                lcd_en <= 1'b0;
                phase  <= P_WAIT;
                cnt    <= (!lcd_rs && lcd_data == 8'h01) ? CLR_LD : CMD_LD;
              end
            end
            P_WAIT: begin
              if (cnt != 27'd0) cnt <= cnt - 27'd1;
              else if (pend) begin
                pend     <= 1'b0;
                cur_code <= mensaje;
                col      <= 4'd0;
                state    <= S_CLEAR;
                phase    <= P_SETUP;
                lcd_data <= 8'h01;
                lcd_rs   <= 1'b0;
              end else begin
                phase <= P_SETUP;
                case (state)
                  S_INIT: begin
                    lcd_rs <= 1'b0;
                    if (init_idx == 3'd5) begin
                      state    <= S_CLEAR;
                      cur_code <= mensaje;
                      lcd_data <= 8'h01;
                    end else begin
                      init_idx <= init_idx + 3'd1;
                      lcd_data <= init_cmd(init_idx + 3'd1);
                    end
                  end
                  S_CLEAR: begin
                    state    <= S_L1ADDR;
                    lcd_rs   <= 1'b0;
                    lcd_data <= 8'h80;
                  end
                  S_L1ADDR: begin
                    state    <= S_L1;
                    col      <= 4'd0;
                    lcd_rs   <= 1'b1;
                    lcd_data <= rom_char(cur_code, 1'b0, 4'd0);
                  end
                  S_L1: begin
                    if (col == 4'd15) begin
                      state    <= S_L2ADDR;
                      col      <= 4'd0;
                      lcd_rs   <= 1'b0;
                      lcd_data <= 8'hC0;
                    end else begin
                      col      <= col + 4'd1;
                      lcd_rs   <= 1'b1;
                      lcd_data <= rom_char(cur_code, 1'b0, col + 4'd1);
                    end
                  end
                  S_L2ADDR: begin
                    state    <= S_L2;
                    col      <= 4'd0;
                    lcd_rs   <= 1'b1;
                    lcd_data <= rom_char(cur_code, 1'b1, 4'd0);
                  end
                  S_L2: begin
                    if (col == 4'd15) begin
                      state <= S_IDLE;
                      col   <= 4'd0;
                      busy  <= 1'b0;
                      done  <= 1'b1;
                    end else begin
                      col      <= col + 4'd1;
                      lcd_rs   <= 1'b1;
                      lcd_data <= rom_char(cur_code, 1'b1, col + 4'd1);
                    end
                  end
                  default: state <= S_IDLE;
                endcase
              end
            end
            default: phase <= P_SETUP;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_msg_writer.sv
// Scoreboard bench for lcd_msg_writer: stimulus pushes the expected LCD byte/done stream,
// a negedge monitor pops it on every lcd_en rise / done pulse and checks bus timing.
module tb_lcd_msg_writer;
  localparam int CLK_HZ = 1_000_000, PWRUP_US = 100, EN_CYC = 2, CMD_US = 5, CLR_US = 20;
  localparam int PWRUP_CYC = 100, CMD_CYC = 5, CLR_CYC = 20;
  localparam int FULL = 36;  // 35 bytes of a rewrite plus its done marker
  localparam logic [9:0] DONE_MARK = 10'h200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] mensaje = 4'd0;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, busy, done;

  lcd_msg_writer #(.CLK_HZ(CLK_HZ), .PWRUP_US(PWRUP_US), .EN_CYC(EN_CYC),
                   .CMD_US(CMD_US), .CLR_US(CLR_US)) dut (
    .Clk(clk), .reset(reset), .mensaje(mensaje), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_en(lcd_en), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int total = 0, bad = 0, rises = 0;
  logic [9:0] exp_q[$];
  string l1[16], l2[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int lim);
    total++;
    if (act < lim) begin
      bad++;
      $display("FAIL %s: got %0d want >= %0d", name, act, lim);
    end
  endtask

  task automatic sb_pop(input logic [9:0] got);
    logic [9:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL sb_extra: got %h, nothing expected", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        bad++;
        $display("FAIL sb_item: got %h want %h", got, e);
      end
    end
  endtask

  // Reference model: message text padded with spaces to 16 columns.
  function automatic logic [7:0] msg_char(input int code, input int line, input int c);
    string s;
    s = (line != 0) ? l2[code] : l1[code];
    if (c < s.len()) return s[c];
    return 8'h20;
  endfunction

  task automatic push_init();
    logic [7:0] cmds[6];
    cmds = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
    foreach (cmds[i]) exp_q.push_back({2'b00, cmds[i]});
  endtask

  // Push the first n items of a complete rewrite of code (n = FULL includes done).
  task automatic push_rewrite(input int code, input int n);
    logic [9:0] seq[$];
    seq.push_back({2'b00, 8'h01});
    seq.push_back({2'b00, 8'h80});
    for (int c = 0; c < 16; c++) seq.push_back({2'b01, msg_char(code, 0, c)});
    seq.push_back({2'b00, 8'hC0});
    for (int c = 0; c < 16; c++) seq.push_back({2'b01, msg_char(code, 1, c)});
    seq.push_back(DONE_MARK);
    for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
  endtask

  // Monitor
  logic [8:0] bus, prev_bus = '0, cur_bus = '0;
  bit prev_en = 0, first_rise = 1;
  int hi = 0, gap = 0, since_rst = 0;

  always @(negedge clk) begin
    bus = {lcd_rs, lcd_data};
    if (reset) begin
      prev_en = 0; hi = 0; gap = 0; since_rst = 0; first_rise = 1;
    end else begin
      since_rst++;
      if (done) begin
        sb_pop(DONE_MARK);
        check("busy_at_done", busy, 0);
      end
      if (lcd_en && !prev_en) begin
        rises++;
        check("rw", lcd_rw, 0);
        check("setup_stable", bus, prev_bus);
        if (first_rise) check_ge("pwrup_wait", since_rst, PWRUP_CYC + 1);
        else check_ge("gap", gap, (cur_bus == 9'h001) ? CLR_CYC : CMD_CYC);
        first_rise = 0;
        sb_pop({1'b0, bus});
        cur_bus = bus;
        hi = 1;
      end else if (lcd_en) begin
        hi++;
        check("en_hold", bus, cur_bus);
      end else begin
        if (prev_en) begin
          check("en_width", hi, EN_CYC);
          gap = 0;
        end
        if (!first_rise) begin
          gap++;
          if (gap <= ((cur_bus == 9'h001) ? CLR_CYC : CMD_CYC)) check("wait_hold", bus, cur_bus);
        end
      end
      prev_en = lcd_en;
    end
    prev_bus = bus;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (rises < target && n < 3000) begin step(); n++; end
    if (rises < target) begin
      total++; bad++;
      $display("FAIL wait_rises: got %0d want %0d", rises, target);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin step(); n++; end
    step();
    check("drain_queue", exp_q.size(), 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic quiet(input int cycles);
    int r0 = rises;
    repeat (cycles) step();
    check("quiet", rises, r0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int cur, d, a, b, k, base, kind;
    l1[0] = "Bienvenido a";    l2[0] = "SCAAD";
    l1[1] = "Inserte moneda";  l2[1] = "para iniciar";
    l1[3] = "Ducha activa";    l2[3] = "Agua caliente";
    l1[4] = "Ducha activa";    l2[4] = "Agua fria";
    l1[5] = "Tiempo agotado";  l2[5] = "Gracias";
    l1[6] = "Pausa";           l2[6] = "Presione boton";
    l1[7] = "Error sensor";    l2[7] = "Llame soporte";
    l1[8] = "Fin de ducha";    l2[8] = "Hasta pronto";
    l1[9] = "Saldo bajo";      l2[9] = "Inserte moneda";
    l1[10] = "Calentando agua"; l2[10] = "Espere por favor";
    l1[11] = "Temperatura alta"; l2[11] = "Ajuste mezcla";
    l1[12] = "Puerta abierta"; l2[12] = "Cierre la puerta";
    l1[13] = "Mantenimiento";  l2[13] = "Fuera de servic.";
    l1[14] = "Modo prueba";    l2[14] = "SCAAD v1.0";
    l1[2] = ""; l2[2] = ""; l1[15] = ""; l2[15] = "";

    // Reset state, then init + first message
    reset = 1'b1; mensaje = 4'd0;
    repeat (3) step();
    check("rst_data", lcd_data, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_en", lcd_en, 0);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    push_init();
    push_rewrite(0, FULL);
    reset = 1'b0;
    wait_drain();
    cur = 0;

    // Idle change: busy next cycle, then a held code stays silent
    push_rewrite(3, FULL);
    mensaje = 4'd3;
    step();
    check("busy_rise", busy, 1);
    wait_drain();
    quiet(10_000);

    // Change 3->5->8 while char 7 of line 1 is on the bus
    push_rewrite(1, FULL);
    mensaje = 4'd1;
    wait_drain();
    base = rises;
    push_rewrite(3, 10);
    push_rewrite(8, FULL);
    mensaje = 4'd3;
    wait_rises(base + 10);
    mensaje = 4'd5;
    step();
    mensaje = 4'd8;
    wait_drain();

    // Unused code: all spaces
    push_rewrite(2, FULL);
    mensaje = 4'd2;
    wait_drain();

    // Reset while lcd_en is high in line 2
    base = rises;
    push_rewrite(0, 25);
    mensaje = 4'd0;
    wait_rises(base + 25);
    reset = 1'b1;
    step();
    check("rst_en_drop", lcd_en, 0);
    check("rst_busy2", busy, 1);
    check("rst_data2", lcd_data, 0);
    check("rst_q_empty", exp_q.size(), 0);
    repeat (2) step();
    push_init();
    push_rewrite(0, FULL);
    reset = 1'b0;
    wait_drain();
    cur = 0;

    // Randomized traffic
    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(0, 2);
      if (kind == 1) begin
        mensaje = 4'(cur);
        quiet(60);
      end else if (kind == 0) begin
        do d = $urandom_range(0, 15); while (d == cur);
        push_rewrite(d, FULL);
        mensaje = 4'(d);
        wait_drain();
        cur = d;
      end else begin
        do d = $urandom_range(0, 15); while (d == cur);
        do a = $urandom_range(0, 15); while (a == d);
        do b = $urandom_range(0, 15); while (b == d);
        k = $urandom_range(1, 35);
        base = rises;
        push_rewrite(d, k);
        push_rewrite(b, FULL);
        mensaje = 4'(d);
        wait_rises(base + k);
        mensaje = 4'(a);
        step();
        mensaje = 4'(b);
        wait_drain();
        cur = b;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
